// File: rtl/serial_mag_cmp_ctrl.sv
// Serial unsigned magnitude comparator: walks both operands MSB-first, two bits
// per cycle, through one shared 2-bit slice and stops at the first differing slice.
module serial_mag_cmp_ctrl #(
  parameter int W = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [W-1:0]                a,
  input  logic [W-1:0]                b,
  output logic                        ready,
  output logic                        done,
  output logic                        gt,
  output logic                        eq,
  output logic                        lt,
  output logic [$clog2(W/2+1)-1:0]    slices,
  output logic [1:0]                  dbg_state
);

  localparam int NS = W / 2;
  localparam int SW = $clog2(NS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [W-1:0]  r_sa;
  logic [W-1:0]  r_sb;
  logic [SW-1:0] r_idx;
  logic [SW-1:0] r_slices;
  logic          r_gt;
  logic          r_eq;
  logic          r_lt;

  logic [1:0]    w_ta;
  logic [1:0]    w_tb;
  logic          w_sgt;
  logic          w_seq;
  logic          w_last;

  // The one shared slice comparator, always looking at the current top slice.
  assign w_ta   = r_sa[W-1:W-2];
  assign w_tb   = r_sb[W-1:W-2];
  assign w_sgt  = (w_ta > w_tb);
  assign w_seq  = (w_ta == w_tb);
  assign w_last = (r_idx == '0);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (!w_seq || w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Result flags are only written on accept (cleared) and on the deciding RUN cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sa     <= '0;
      r_sb     <= '0;
      r_idx    <= '0;
      r_slices <= '0;
      r_gt     <= 1'b0;
      r_eq     <= 1'b0;
      r_lt     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sa     <= a;
            r_sb     <= b;
            r_idx    <= SW'(NS - 1);
            r_slices <= '0;
            r_gt     <= 1'b0;
            r_eq     <= 1'b0;
            r_lt     <= 1'b0;
          end
        end
        S_RUN: begin
          r_slices <= SW'(NS) - r_idx;
          if (w_sgt) begin
            r_gt <= 1'b1;
          end else if (w_seq) begin
            if (w_last) begin
              r_eq <= 1'b1;
            end else begin
              r_sa  <= r_sa << 2;
              r_sb  <= r_sb << 2;
              r_idx <= r_idx - 1'b1;
            end
          end else begin
            r_lt <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready     = (r_state == S_IDLE);
  assign done      = (r_state == S_DONE);
  assign gt        = r_gt;
  assign eq        = r_eq;
  assign lt        = r_lt;
  assign slices    = r_slices;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_mag_cmp_ctrl.sv
// Bench for serial_mag_cmp_ctrl (W=8): directed latency/flag scenarios plus random
// compares; every done pulse is checked against an expected-result queue.
module tb_serial_mag_cmp_ctrl;

  localparam int W  = 8;
  localparam int NS = W / 2;
  localparam int SW = $clog2(NS + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          ready;
  logic          done;
  logic          gt;
  logic          eq;
  logic          lt;
  logic [SW-1:0] slices;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  // Expected {gt, eq, lt, slices} per accepted compare.
  logic [SW+2:0] exp_q[$];

  serial_mag_cmp_ctrl #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .done      (done),
    .gt        (gt),
    .eq        (eq),
    .lt        (lt),
    .slices    (slices),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [SW-1:0] exp_slices(input logic [W-1:0] x, input logic [W-1:0] y);
    for (int k = 0; k < NS; k++) begin
      if (x[W-1-2*k -: 2] != y[W-1-2*k -: 2]) return SW'(k + 1);
    end
    return SW'(NS);
  endfunction

  function automatic logic [SW+2:0] exp_entry(input logic [W-1:0] x, input logic [W-1:0] y);
    return {(x > y), (x == y), (x < y), exp_slices(x, y)};
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!reset && done) begin
      logic [SW+2:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done got=%b%b%b/%0d expected no done", gt, eq, lt, slices);
      end else begin
        e = exp_q.pop_front();
        if ({gt, eq, lt, slices} !== e) begin
          errors++;
          $display("FAIL sb_result got gt/eq/lt/slices=%b%b%b/%0d expected=%b%b%b/%0d",
                   gt, eq, lt, slices, e[SW+2], e[SW+1], e[SW], e[SW-1:0]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Starts at cycle 0 (DUT idle); returns in the cycle done is seen, dcyc = that cycle.
  task automatic drive_compare(input logic [W-1:0] x, input logic [W-1:0] y, output int dcyc);
    start = 1'b1;
    a = x;
    b = y;
    exp_q.push_back(exp_entry(x, y));
    step();
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    dcyc = 1;
    while (done !== 1'b1 && dcyc < NS + 3) begin
      step();
      a = W'($urandom);
      b = W'($urandom);
      dcyc++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL compare_timeout a=%h b=%h got no done by cycle %0d", x, y, dcyc);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    a = 8'hFF;
    b = 8'h00;
    step();
    step();
    reset = 1'b0;
    start = 1'b0;
    checks++;
    if ({ready, done, gt, eq, lt, slices} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, SW'(0)}) begin
      errors++;
      $display("FAIL reset_state got rdy/done/gt/eq/lt/slices=%b%b%b%b%b/%0d expected 10000/0",
               ready, done, gt, eq, lt, slices);
    end
  endtask

  task automatic test_early_gt();
    start = 1'b1;
    a = 8'hC5;
    b = 8'h3F;
    exp_q.push_back(exp_entry(8'hC5, 8'h3F));
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL early_gt_ready0 got=%b expected=1", ready);
    end
    for (int cyc = 1; cyc <= 10; cyc++) begin
      step();
      start = 1'b0;
      checks++;
      if (done !== (cyc == 2)) begin
        errors++;
        $display("FAIL early_gt_done cycle %0d got=%b expected=%b", cyc, done, (cyc == 2));
      end
      if (cyc >= 2) begin
        checks++;
        if ({gt, eq, lt, slices} !== {3'b100, SW'(1)}) begin
          errors++;
          $display("FAIL early_gt_hold cycle %0d got=%b%b%b/%0d expected=100/1", cyc, gt, eq, lt, slices);
        end
      end
    end
  endtask

  task automatic test_lsb_diff();
    int d;
    drive_compare(8'h5A, 8'h5B, d);
    checks++;
    if (d != 5 || lt !== 1'b1 || slices !== SW'(4)) begin
      errors++;
      $display("FAIL lsb_diff got done_cycle=%0d lt=%b slices=%0d expected 5/1/4", d, lt, slices);
    end
    step();
  endtask

  task automatic test_equal_then_restart();
    int d;
    drive_compare(8'hA7, 8'hA7, d);
    checks++;
    if (d != 5 || {gt, eq, lt, slices} !== {3'b010, SW'(4)}) begin
      errors++;
      $display("FAIL equal got done_cycle=%0d flags=%b%b%b/%0d expected 5 010/4", d, gt, eq, lt, slices);
    end
    step();  // cycle 6
    step();  // cycle 7
    start = 1'b1;
    a = 8'h00;
    b = 8'hFF;
    exp_q.push_back(exp_entry(8'h00, 8'hFF));
    step();  // cycle 8
    start = 1'b0;
    checks++;
    if ({done, gt, eq, lt, slices} !== {4'b0000, SW'(0)}) begin
      errors++;
      $display("FAIL restart_clear got done/flags=%b %b%b%b/%0d expected 0 000/0", done, gt, eq, lt, slices);
    end
    step();  // cycle 9
    checks++;
    if ({done, gt, eq, lt, slices} !== {4'b1001, SW'(1)}) begin
      errors++;
      $display("FAIL restart_result got done/flags=%b %b%b%b/%0d expected 1 001/1", done, gt, eq, lt, slices);
    end
    step();
  endtask

  task automatic test_busy_ignore();
    start = 1'b1;
    a = 8'h10;
    b = 8'h11;
    exp_q.push_back(exp_entry(8'h10, 8'h11));
    step();  // cycle 1
    start = 1'b0;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_ready cycle 1 got=%b expected=0", ready);
    end
    step();  // cycle 2
    start = 1'b1;
    a = 8'hFF;
    b = 8'h00;
    for (int cyc = 2; cyc <= 5; cyc++) begin
      checks++;
      if (ready !== 1'b0 || done !== (cyc == 5)) begin
        errors++;
        $display("FAIL busy_hs cycle %0d got ready=%b done=%b expected 0/%b", cyc, ready, done, (cyc == 5));
      end
      if (cyc < 5) begin
        step();
        a = W'($urandom);
        b = W'($urandom);
      end
    end
    checks++;
    if ({gt, eq, lt, slices} !== {3'b001, SW'(4)}) begin
      errors++;
      $display("FAIL busy_result got=%b%b%b/%0d expected=001/4", gt, eq, lt, slices);
    end
    step();  // cycle 6
    start = 1'b0;
    step();  // cycle 7
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL busy_after got ready=%b done=%b expected 1/0", ready, done);
    end
  endtask

  task automatic test_reset_abort();
    int d;
    start = 1'b1;
    a = 8'h12;
    b = 8'h13;
    step();  // cycle 1
    start = 1'b0;
    step();  // cycle 2
    reset = 1'b1;
    step();  // cycle 3
    reset = 1'b0;
    checks++;
    if ({ready, done, gt, eq, lt, slices} !== {5'b10000, SW'(0)}) begin
      errors++;
      $display("FAIL abort_state got rdy/done/flags=%b%b %b%b%b/%0d expected 10 000/0",
               ready, done, gt, eq, lt, slices);
    end
    for (int cyc = 4; cyc <= 10; cyc++) begin
      step();
      checks++;
      if (done !== 1'b0 || ready !== 1'b1) begin
        errors++;
        $display("FAIL abort_quiet cycle %0d got done=%b ready=%b expected 0/1", cyc, done, ready);
      end
    end
    drive_compare(8'h80, 8'h40, d);
    checks++;
    if (d != 2 || {gt, eq, lt, slices} !== {3'b100, SW'(1)}) begin
      errors++;
      $display("FAIL abort_next got done_cycle=%0d flags=%b%b%b/%0d expected 2 100/1", d, gt, eq, lt, slices);
    end
    step();
  endtask

  task automatic test_back_to_back();
    start = 1'b1;
    a = 8'h33;
    b = 8'h33;
    for (int cyc = 0; cyc <= 17; cyc++) begin
      checks++;
      if (ready !== (cyc % 6 == 0) || done !== (cyc % 6 == 5)) begin
        errors++;
        $display("FAIL b2b cycle %0d got ready=%b done=%b expected %b/%b",
                 cyc, ready, done, (cyc % 6 == 0), (cyc % 6 == 5));
      end
      if (ready === 1'b1) exp_q.push_back(exp_entry(8'h33, 8'h33));
      step();
    end
    start = 1'b0;
    step();
  endtask

  task automatic test_random();
    int d;
    logic [W-1:0] x;
    logic [W-1:0] y;
    for (int n = 0; n < 24; n++) begin
      x = W'($urandom);
      y = W'($urandom);
      if (n % 2 == 0) y = {x[W-1:2], 2'($urandom_range(0, 3))};
      drive_compare(x, y, d);
      checks++;
      if (d != int'(exp_slices(x, y)) + 1) begin
        errors++;
        $display("FAIL rand_latency a=%h b=%h got done_cycle=%0d expected=%0d", x, y, d, int'(exp_slices(x, y)) + 1);
      end
      step();
      checks++;
      if (ready !== 1'b1) begin
        errors++;
        $display("FAIL rand_ready a=%h b=%h got=%b expected=1", x, y, ready);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    step();
    step();
    reset = 1'b0;
    test_reset();
    test_early_gt();
    test_lsb_diff();
    test_equal_then_restart();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    test_random();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d pending results expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_mag_cmp_ctrl.md
Name: serial_mag_cmp_ctrl

Overview:
- Sequencer that compares two W-bit unsigned operands MSB-first, two bits per cycle.
- Reuses a single 2-bit greater-than/equal slice, so a wide magnitude compare costs one small comparator and a few registers.
- Terminates early as soon as a slice pair differs.
- Sits between a requesting FSM, which drives start and operands, and any consumer of the gt/eq/lt flags.

Parameters:
- W, 8, operand width in bits. Must be even and at least 2. Number of slices is NS = W/2.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a compare. Accepted only when ready=1.
- a  input  W  operand A, sampled in the cycle start is accepted
- b  input  W  operand B, sampled in the cycle start is accepted
- ready  output  1  high in IDLE only
- done  output  1  single-cycle pulse when the result is valid
- gt  output  1  registered result, a > b
- eq  output  1  registered result, a == b
- lt  output  1  registered result, a < b
- slices  output  $clog2(NS+1)  number of slices evaluated for the last result, 1..NS

Behaviour:
- Reset:
  - Synchronous, active-high, single clock clk. Reset is sampled on the rising edge of clk.
  - On reset: state=IDLE, ready=1, done=0, gt=eq=lt=0, slices=0, internal shift registers and slice counter cleared.
  - Reset asserted in any state, including mid-RUN, aborts the compare. No done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - If start=1 at an edge: load a and b into shift registers sa and sb, load idx=NS-1, clear gt/eq/lt/slices, go to RUN.
- RUN:
  - ready=0.
  - Each cycle, compare top slices ta=sa[W-1:W-2] and tb=sb[W-1:W-2] with the 2-bit slice:
    - sgt = ta > tb
    - seq = ta == tb
    - slt = otherwise
  - If sgt: set gt=1, go to DONE.
  - If slt: set lt=1, go to DONE.
  - If seq and idx==0: set eq=1, go to DONE.
  - If seq and idx!=0: shift sa and sb left by 2 (zero fill), idx decrements, stay in RUN.
  - slices = NS - idx, registered on the same edge as the decision.
- DONE:
  - done=1 for exactly one cycle, ready=0.
  - Next state is always IDLE.
- Result hold:
  - gt/eq/lt/slices hold their value after DONE until the next accepted start, which clears them.
  - Exactly one of gt/eq/lt is 1 whenever done=1.
- Latency:
  - Start accepted in cycle 0. Deciding slice j (0 = MSB slice) is evaluated in cycle j+1.
  - done is high in cycle j+2.
  - Minimum 2 cycles. Maximum NS+1 cycles (equal operands, or difference only in the LSB slice).
  - Throughput: a new start is accepted at the earliest in the cycle after done.
- start while not IDLE (RUN or DONE): ignored. Operands are not resampled and results are unaffected.
- Operand changes after acceptance have no effect (captured copies are used).
- start held high continuously: one compare per (latency+1) cycles. Each accepted in IDLE.
- W=2: NS=1. RUN lasts exactly one cycle, and every compare takes 2 cycles.

Test Plan:
- W=8, a=0xC5, b=0x3F, start pulse in cycle 0 -> done in cycle 2 only. gt=1, eq=0, lt=0, slices=1. Flags hold through cycle 10.
- a=0x5A, b=0x5B -> slices 01/01, 01/01, 10/10 equal, then 10 vs 11 -> done in cycle 5. lt=1, slices=4.
- a=b=0xA7 -> done in cycle 5. eq=1, gt=lt=0, slices=4. Then a=0x00, b=0xFF started in cycle 7 -> flags cleared in cycle 8, done in cycle 9 with lt=1, slices=1.
- Start a=0x10, b=0x11. In cycle 2 pulse start with a=0xFF, b=0x00 and change a/b inputs every cycle -> second start ignored, ready=0 in cycles 1-4. Done in cycle 5 with lt=1, slices=4.
- Start a=0x12, b=0x13, assert reset in cycle 2 -> cycle 3 onward: ready=1, done=0, gt=eq=lt=0, slices=0, and no done pulse ever. A new compare after reset (a=0x80, b=0x40) gives gt=1, slices=1.
- start tied high with a=0x33, b=0x33 -> done pulses in cycles 5, 11, 17. ready high in cycles 0, 6, 12. eq=1 at each done.
